// File: rtl/op_exec_responder.sv
// Responder end of the start/done op handshake: latches one opcode plus operands,
// waits a condition/family dependent latency, then returns the result with a done pulse.
module op_exec_responder #(
  parameter int unsigned B2_LAT_BIN  = 1,
  parameter int unsigned B2_LAT_DEC  = 8,
  parameter int unsigned B2_LAT_DUO  = 6,
  parameter int unsigned B10_LAT_DEC = 1,
  parameter int unsigned B10_LAT_BIN = 6,
  parameter int unsigned B10_LAT_DUO = 6,
  parameter int unsigned B12_LAT_DUO = 1,
  parameter int unsigned B12_LAT_BIN = 6,
  parameter int unsigned B12_LAT_DEC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  cond_sel,
  input  logic [3:0]  opcode,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err
);

  localparam logic [3:0] OP_BIN_ADD   = 4'd0;
  localparam logic [3:0] OP_BIN_SUB   = 4'd1;
  localparam logic [3:0] OP_BIN_MUL   = 4'd2;
  localparam logic [3:0] OP_DEC_ADD   = 4'd3;
  localparam logic [3:0] OP_DEC_SUB   = 4'd4;
  localparam logic [3:0] OP_DEC_MUL10 = 4'd5;
  localparam logic [3:0] OP_DUO_ADD12 = 4'd6;
  localparam logic [3:0] OP_DUO_SUB12 = 4'd7;
  localparam logic [3:0] OP_DUO_MUL3  = 4'd8;

  localparam logic [16:0] DEC_MOD = 17'd10000;
  localparam logic [16:0] DUO_MOD = 17'd20736;

  function automatic logic [15:0] f_clamp(input int unsigned v);
    return (v == 0) ? 16'd1 : ((v > 32'd65535) ? 16'hFFFF : v[15:0]);
  endfunction

  function automatic logic [15:0] f_min3(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    logic [15:0] m;
    m = (x < y) ? x : y;
    return (m < z) ? m : z;
  endfunction

  localparam logic [15:0] L_BIN0 = f_clamp(B2_LAT_BIN);
  localparam logic [15:0] L_BIN1 = f_clamp(B10_LAT_BIN);
  localparam logic [15:0] L_BIN2 = f_clamp(B12_LAT_BIN);
  localparam logic [15:0] L_DEC0 = f_clamp(B2_LAT_DEC);
  localparam logic [15:0] L_DEC1 = f_clamp(B10_LAT_DEC);
  localparam logic [15:0] L_DEC2 = f_clamp(B12_LAT_DEC);
  localparam logic [15:0] L_DUO0 = f_clamp(B2_LAT_DUO);
  localparam logic [15:0] L_DUO1 = f_clamp(B10_LAT_DUO);
  localparam logic [15:0] L_DUO2 = f_clamp(B12_LAT_DUO);
  localparam logic [15:0] L_BIN3 = f_min3(L_BIN0, L_BIN1, L_BIN2);
  localparam logic [15:0] L_DEC3 = f_min3(L_DEC0, L_DEC1, L_DEC2);
  localparam logic [15:0] L_DUO3 = f_min3(L_DUO0, L_DUO1, L_DUO2);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [3:0]  r_op;
  logic [15:0] r_a, r_b;
  logic [15:0] r_result;
  logic        r_err;
  logic        w_accept;
  logic        w_finish;
  logic [15:0] w_lat;
  logic [15:0] w_res;
  logic        w_err;

  assign w_accept = start && (r_state != S_EXEC);
  assign w_finish = (r_state == S_EXEC) && (r_cnt <= 16'd1);

  // Latency is chosen from the incoming opcode/cond so the counter can load on accept.
  always_comb begin
    w_lat = 16'd1;
    unique case (opcode)
      OP_BIN_ADD, OP_BIN_SUB, OP_BIN_MUL: begin
        unique case (cond_sel)
          2'd0:    w_lat = L_BIN0;
          2'd1:    w_lat = L_BIN1;
          2'd2:    w_lat = L_BIN2;
          default: w_lat = L_BIN3;
        endcase
      end
      OP_DEC_ADD, OP_DEC_SUB, OP_DEC_MUL10: begin
        unique case (cond_sel)
          2'd0:    w_lat = L_DEC0;
          2'd1:    w_lat = L_DEC1;
          2'd2:    w_lat = L_DEC2;
          default: w_lat = L_DEC3;
        endcase
      end
      OP_DUO_ADD12, OP_DUO_SUB12, OP_DUO_MUL3: begin
        unique case (cond_sel)
          2'd0:    w_lat = L_DUO0;
          2'd1:    w_lat = L_DUO1;
          2'd2:    w_lat = L_DUO2;
          default: w_lat = L_DUO3;
        endcase
      end
      default: w_lat = 16'd1;
    endcase
  end

  logic [16:0] w_a17, w_b17, w_sum17, w_m10, w_m3;
  logic        w_dec_bad_a, w_dec_bad_b, w_duo_bad_a, w_duo_bad_b;

  assign w_a17       = {1'b0, r_a};
  assign w_b17       = {1'b0, r_b};
  assign w_sum17     = w_a17 + w_b17;
  assign w_m10       = (({w_a17[13:0], 3'b000}) + ({w_a17[15:0], 1'b0})) % DEC_MOD;
  assign w_m3        = ({w_a17[15:0], 1'b0}) + w_a17;
  assign w_dec_bad_a = (w_a17 >= DEC_MOD);
  assign w_dec_bad_b = (w_b17 >= DEC_MOD);
  assign w_duo_bad_a = (w_a17 >= DUO_MOD);
  assign w_duo_bad_b = (w_b17 >= DUO_MOD);

  always_comb begin
    logic [16:0] t;
    t     = 17'd0;
    w_res = 16'd0;
    w_err = 1'b0;
    unique case (r_op)
      OP_BIN_ADD: w_res = r_a + r_b;
      OP_BIN_SUB: w_res = r_a - r_b;
      OP_BIN_MUL: w_res = r_a[7:0] * r_b[7:0];
      OP_DEC_ADD: begin
        w_err = w_dec_bad_a || w_dec_bad_b;
        t     = (w_sum17 >= DEC_MOD) ? (w_sum17 - DEC_MOD) : w_sum17;
      end
      OP_DEC_SUB: begin
        w_err = w_dec_bad_a || w_dec_bad_b;
        t     = (w_a17 >= w_b17) ? (w_a17 - w_b17) : (w_a17 + DEC_MOD - w_b17);
      end
      OP_DEC_MUL10: begin
        w_err = w_dec_bad_a;
        t     = w_m10;
      end
      OP_DUO_ADD12: begin
        w_err = w_duo_bad_a || w_duo_bad_b;
        t     = (w_sum17 >= DUO_MOD) ? (w_sum17 - DUO_MOD) : w_sum17;
      end
      OP_DUO_SUB12: begin
        w_err = w_duo_bad_a || w_duo_bad_b;
        t     = (w_a17 >= w_b17) ? (w_a17 - w_b17) : (w_a17 + DUO_MOD - w_b17);
      end
      OP_DUO_MUL3: begin
        w_err = w_duo_bad_a;
        // 3a stays below 3*12^4, so at most two subtractions reduce it.
        if (w_m3 >= {DUO_MOD[15:0], 1'b0}) t = w_m3 - {DUO_MOD[15:0], 1'b0};
        else if (w_m3 >= DUO_MOD)          t = w_m3 - DUO_MOD;
        else                               t = w_m3;
      end
      default: w_err = 1'b1;
    endcase
    if (t != 17'd0) w_res = t[15:0];
    if (w_err)      w_res = 16'd0;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        w_state_next = S_IDLE;
        if (w_accept) begin
          w_state_next = S_EXEC;
          w_cnt_next   = w_lat;
        end
      end
      S_EXEC: begin
        if (w_finish) w_state_next = S_RESP;
        else          w_cnt_next   = r_cnt - 16'd1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 4'd0;
      r_a      <= 16'd0;
      r_b      <= 16'd0;
      r_result <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= opcode;
        r_a  <= op_a;
        r_b  <= op_b;
      end
      if (w_finish) begin
        r_result <= w_res;
        r_err    <= w_err;
      end
    end
  end

  assign busy   = (r_state == S_EXEC);
  assign done   = (r_state == S_RESP);
  assign result = r_result;
  assign err    = r_err;

endmodule
